// File: rtl/sprite_mover_if.sv
// sprite_mover_if: request/descriptor bundle between the video timing side and sprite_mover
interface sprite_mover_if #(
  parameter int FW = 3
);
  logic          nf_in;
  logic          spawn_in;
  logic          kill_in;
  logic [10:0]   start_x;
  logic [9:0]    start_y;
  logic [10:0]   target_x;
  logic [9:0]    target_y;
  logic          sprite_valid;
  logic [10:0]   sprite_x;
  logic [9:0]    sprite_y;
  logic [FW-1:0] sprite_frame_number;
  logic          arrived_out;
  logic          hit_out;
  modport master (
    output nf_in, spawn_in, kill_in, start_x, start_y, target_x, target_y,
    input  sprite_valid, sprite_x, sprite_y, sprite_frame_number, arrived_out, hit_out
  );
  modport slave (
    input  nf_in, spawn_in, kill_in, start_x, start_y, target_x, target_y,
    output sprite_valid, sprite_x, sprite_y, sprite_frame_number, arrived_out, hit_out
  );
endinterface

// File: rtl/sprite_mover.sv
// sprite_mover: walks a sprite from spawn to target on new_frame pulses, then loops its action animation
module sprite_mover #(
  parameter int NUM_FRAMES  = 5,
  parameter int WALK_FRAMES = 3,
  parameter int STEP        = 2,
  parameter int ANIM_DIV    = 8,
  parameter int FW          = $clog2(NUM_FRAMES)
) (
  input logic           clk_pixel,
  input logic           sys_rst,
  sprite_mover_if.slave bus
);
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WALK   = 2'd1;
  localparam logic [1:0] ACTION = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [10:0]   x_q, x_d, y_q, y_d, tx_q, tx_d, ty_q, ty_d;
  logic [10:0]   sx_q, sx_d, sy_q, sy_d, stx_q, stx_d, sty_q, sty_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [AW-1:0] anim_q, anim_d, anim_inc;
  logic          valid_q, valid_d, arr_q, arr_d, hit_q, hit_d;
  logic          spawn_pend_q, spawn_pend_d, kill_pend_q, kill_pend_d;
  logic          kill_e, spawn_e, anim_wrap, last_frame;
  logic [10:0]   nx, ny;

  // y is carried at 11 bits so both axes share one stepping function; bit 10 stays 0
  function automatic logic [10:0] mv(input logic [10:0] p, input logic [10:0] t);
    logic signed [11:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, p});
    return (d > STEP) ? p + 11'(STEP) : (d < -STEP) ? p - 11'(STEP) : t;
  endfunction

  always_comb begin
    kill_e       = kill_pend_q | bus.kill_in;
    spawn_e      = spawn_pend_q | bus.spawn_in;
    sx_d         = bus.spawn_in ? bus.start_x : sx_q;
    sy_d         = bus.spawn_in ? {1'b0, bus.start_y} : sy_q;
    stx_d        = bus.spawn_in ? bus.target_x : stx_q;
    sty_d        = bus.spawn_in ? {1'b0, bus.target_y} : sty_q;
    nx           = mv(x_q, tx_q);
    ny           = mv(y_q, ty_q);
    anim_wrap    = anim_q == AW'(ANIM_DIV - 1);
    anim_inc     = anim_wrap ? '0 : anim_q + 1'b1;
    last_frame   = frame_q == FW'(NUM_FRAMES - 1);
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    frame_d      = frame_q;
    anim_d       = anim_q;
    valid_d      = valid_q;
    arr_d        = arr_q;
    hit_d        = 1'b0;
    kill_pend_d  = kill_e;
    spawn_pend_d = spawn_e;
    if (bus.nf_in) begin
      kill_pend_d  = 1'b0;
      spawn_pend_d = 1'b0;
      if (kill_e) begin
        state_d = IDLE;
        valid_d = 1'b0;
        arr_d   = 1'b0;
      end else if (spawn_e) begin
        x_d     = sx_d;
        y_d     = sy_d;
        tx_d    = stx_d;
        ty_d    = sty_d;
        frame_d = '0;
        anim_d  = '0;
        state_d = WALK;
        valid_d = 1'b1;
        arr_d   = 1'b0;
      end else if (state_q == WALK) begin
        if (x_q == tx_q && y_q == ty_q) begin
          state_d = ACTION;
          frame_d = FW'(WALK_FRAMES);
          anim_d  = '0;
          arr_d   = 1'b1;
        end else begin
          x_d     = nx;
          y_d     = ny;
          anim_d  = anim_inc;
          frame_d = !anim_wrap ? frame_q : (frame_q == FW'(WALK_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end
      end else if (state_q == ACTION) begin
        anim_d  = anim_inc;
        frame_d = !anim_wrap ? frame_q : last_frame ? FW'(WALK_FRAMES) : frame_q + 1'b1;
        hit_d   = anim_wrap & last_frame;
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      stx_q        <= '0;
      sty_q        <= '0;
      frame_q      <= '0;
      anim_q       <= '0;
      valid_q      <= 1'b0;
      arr_q        <= 1'b0;
      hit_q        <= 1'b0;
      spawn_pend_q <= 1'b0;
      kill_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      stx_q        <= stx_d;
      sty_q        <= sty_d;
      frame_q      <= frame_d;
      anim_q       <= anim_d;
      valid_q      <= valid_d;
      arr_q        <= arr_d;
      hit_q        <= hit_d;
      spawn_pend_q <= spawn_pend_d;
      kill_pend_q  <= kill_pend_d;
    end
  end

  assign bus.sprite_valid        = valid_q;
  assign bus.sprite_x            = x_q;
  assign bus.sprite_y            = y_q[9:0];
  assign bus.sprite_frame_number = frame_q;
  assign bus.arrived_out         = arr_q;
  assign bus.hit_out             = hit_q;
endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Produces the per-sprite descriptor that the graphics block consumes: sprite_valid, sprite_x, sprite_y and sprite_frame_number.
- Walks a sprite from a spawn point to a target point and then loops its action animation.
- Signals each completed action cycle (a "hit").
- Lives in the clk_pixel domain and updates only on the new_frame pulse from video_sig_gen, so descriptors stay constant during active draw.

Parameters:
- NUM_FRAMES, 5, total animation frames in the sprite sheet (frame indices 0..NUM_FRAMES-1).
- WALK_FRAMES, 3, frames 0..WALK_FRAMES-1 are walk frames; WALK_FRAMES..NUM_FRAMES-1 are action frames. Requires 1 <= WALK_FRAMES < NUM_FRAMES.
- STEP, 2, maximum pixels moved per axis per video frame (>=1).
- ANIM_DIV, 8, video frames per animation frame (>=1).
- FW, $clog2(NUM_FRAMES), frame index width.

Ports:
- clk_pixel  input  1  pixel clock
- sys_rst  input  1  synchronous active-high reset
- nf_in  input  1  new_frame pulse, 1 cycle wide, from video_sig_gen
- spawn_in  input  1  1-cycle request to (re)spawn the sprite
- kill_in  input  1  1-cycle request to despawn the sprite
- start_x  input  11  spawn x; sampled when spawn_in=1
- start_y  input  10  spawn y; sampled when spawn_in=1
- target_x  input  11  target x; sampled when spawn_in=1
- target_y  input  10  target y; sampled when spawn_in=1
- sprite_valid  output  1  sprite drawn when 1
- sprite_x  output  11  sprite top-left x
- sprite_y  output  10  sprite top-left y
- sprite_frame_number  output  FW  sheet frame index
- arrived_out  output  1  level, 1 while in ACTION
- hit_out  output  1  1-cycle pulse at each completed action cycle

Behaviour:
- Reset: state IDLE; sprite_valid=0, sprite_x=0, sprite_y=0, sprite_frame_number=0, arrived_out=0, hit_out=0; anim counter=0; pending flags clear. Reset has priority over every other input.
- States are IDLE, WALK and ACTION. All registered outputs except hit_out change only on the clock edge where nf_in=1 is sampled; they are visible the following cycle.
- Request latching:
  - spawn_in=1 latches start/target into shadow registers and sets spawn_pend.
  - kill_in=1 sets kill_pend.
  - Requests arriving on the same cycle as nf_in are applied at that nf_in.
  - A later spawn before nf_in overwrites the shadow registers; the last one wins.
- At each nf_in, evaluated in priority order:
  1. kill_pend: state IDLE, sprite_valid=0, arrived_out=0; position and frame are held. Both pending flags clear, so kill beats a simultaneous spawn.
  2. spawn_pend, from any state: position=start, frame=0, anim counter=0, state WALK, sprite_valid=1, arrived_out=0; spawn_pend clears.
  3. WALK:
     - If position == target: go to ACTION, frame=WALK_FRAMES, anim counter=0, arrived_out=1. No movement on that edge.
     - Otherwise each axis moves independently toward its target by min(STEP, |target-pos|). No overshoot.
     - Anim counter increments; at ANIM_DIV-1 it wraps to 0 and frame advances, wrapping WALK_FRAMES-1 -> 0.
  4. ACTION:
     - Anim counter increments; at wrap, frame advances.
     - When the frame wraps NUM_FRAMES-1 -> WALK_FRAMES, hit_out pulses high for exactly one clk_pixel cycle, the cycle after that nf_in.
  5. IDLE: no change.
- Arithmetic: differences are computed at width+1 bits signed. Outputs never leave the range spanned by start and target.
- Reset asserted mid-walk discards pending requests and shadow values.

Test Plan:
- Reset then 3 nf_in -> all outputs 0, sprite_valid=0, hit_out never 1.
- Spawn (100,200)->(110,200), then nf_in x6 -> after nf1 valid=1, x=100, frame 0; nf2..nf6 give x=102,104,106,108,110, y=200, frame 0 throughout; nf7 -> arrived_out=1, frame=3.
- Spawn (100,200)->(105,195), then 4 nf -> after nf1 position (100,200); then (102,198), (104,196), (105,195) with no overshoot. The next nf enters ACTION.
- In ACTION with ANIM_DIV=8 -> frame 3 for 8 nf, then 4 for 8 nf, then back to 3. hit_out is high for exactly one cycle right after the 4->3 nf, and repeats every 16 nf.
- spawn_in and kill_in between the same pair of nf -> next nf gives valid=0, IDLE; a subsequent spawn alone revalidates at the start position.
- Respawn mid-walk at x=104 to start (50,50) -> next nf gives position (50,50), frame 0, WALK. Asserting sys_rst mid-walk -> all outputs 0 the next cycle.
